mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory stage directly downstream of alu: consumes its effective_address_o and the store value (rt), and performs the data-memory access over an Avalon-MM-style bus with waitrequest.
- Generates byte lanes and store-data placement for SB/SH/SW, and extracts plus sign- or zero-extends load results for LB/LBU/LH/LHU/LW.
- Returns the result to the writeback path with a one-cycle done pulse.
- Traps misaligned accesses without touching the bus.

Parameters:
- ADDR_W, 32, bus/byte address width
- DATA_W, 32, bus data width (fixed at 32; other values unsupported)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid_i  in  1  access request from the stage feeding this block
- req_ready_o  out  1  high only in IDLE; request accepted when req_valid_i && req_ready_o
- op_i  in  mem_op_t (3)  MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW
- addr_i  in  32  byte address (alu effective_address_o)
- wdata_i  in  32  store value, right-justified (raw rt)
- avm_address_o  out  32  word-aligned address ({addr[31:2],2'b00})
- avm_read_o  out  1  read strobe
- avm_write_o  out  1  write strobe
- avm_writedata_o  out  32  lane-placed store data
- avm_byteenable_o  out  4  active byte lanes
- avm_waitrequest_i  in  1  slave stall
- avm_readdata_i  in  32  read data, valid in the cycle read && !waitrequest
- done_o  out  1  one-cycle completion pulse
- load_data_o  out  32  extended load result; held until the next done_o
- misaligned_o  out  1  qualifies done_o: address error, no bus access made

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - avm_read_o, avm_write_o, done_o, misaligned_o = 0.
  - avm_address_o, avm_writedata_o, avm_byteenable_o, load_data_o = 0.
  - req_ready_o = 1.
- State machine IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - On accept, register op, addr, wdata.
  - If misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0), go to RESP with misaligned flag set.
  - Otherwise go to BUSY.
- BUSY:
  - Assert avm_read_o (load) or avm_write_o (store); address, writedata and byteenable are registered and stable for the whole of BUSY.
  - Stay while avm_waitrequest_i=1.
  - On the cycle waitrequest=0: for loads, capture extended readdata into load_data_o; go to RESP.
- RESP:
  - done_o=1 for exactly one cycle; misaligned_o=1 only for a trapped request; go to IDLE.
  - load_data_o unchanged for stores and for misaligned requests.
- Latency:
  - Accept at cycle N, strobe from N+1, done at N+2+W, where W = waitrequest stall cycles.
  - Misaligned: done at N+1.
  - Back-to-back: next accept is no earlier than the cycle after done.
- Endianness: little-endian; byte at addr offset k occupies bits [8k+7:8k].
- Byteenable:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
  - Loads use the same enables.
- Store data placement:
  - SB replicates wdata[7:0] to all lanes.
  - SH replicates wdata[15:0] to both halves.
  - SW passes wdata through.
- Load extract: select lane(s) by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Strobes: never both high; neither is high outside BUSY.
- Requests while not ready are ignored; the requester must hold them.
- Reset mid-BUSY: strobes drop immediately (async) and the transaction is abandoned with no done_o.

Decomposition:
- Package codes gains:
  - mem_op_t enum (3 bits)
  - localparam BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111
- The FSM state enum stays local to the module.
- One combinational sub-module, mem_lane_align (op, addr[1:0], wdata, readdata -> byteenable, writedata, load_data, misaligned), instantiated by mem_access_unit.

Test Plan:
- SW addr=0x100 wdata=0xDEADBEEF, waitrequest=0 -> one-cycle write, address 0x100, BE=4'b1111, writedata 0xDEADBEEF, done at N+2, misaligned_o=0.
- LB addr=0x203 with readdata=0x80FF1234 -> BE=4'b1000, load_data_o=0xFFFFFF80; repeat with LBU -> 0x00000080.
- LH addr=0x302, readdata=0x9ABC0000 -> BE=4'b1100, load_data_o=0xFFFF9ABC; LHU -> 0x00009ABC.
- SB addr=0x401 wdata=0x000000A5, waitrequest high 3 cycles -> avm_write_o high 4 cycles with address, writedata 0xA5A5A5A5 and BE=4'b0010 stable; done at N+5; req_ready_o low until done.
- LW addr=0x502 -> no read strobe ever, done_o and misaligned_o at N+1, load_data_o unchanged.
- rst_n pulled low mid-BUSY during a read -> avm_read_o low asynchronously, no done_o; after release, req_ready_o=1 and a fresh LW completes normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types and constants for the memory access stage
// Purpose: memory operation codes, byte-enable patterns and a load/store classifier.
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        MEM_LB  = 3'd0,
        MEM_LBU = 3'd1,
        MEM_LH  = 3'd2,
        MEM_LHU = 3'd3,
        MEM_LW  = 3'd4,
        MEM_SB  = 3'd5,
        MEM_SH  = 3'd6,
        MEM_SW  = 3'd7
    } mem_op_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic is_store(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for loads and stores
// Purpose: purely combinational lane logic for a little-endian 32-bit bus.
// Ports:
//   op_i          memory operation
//   addr_lo_i     byte offset within the word
//   wdata_i       right-justified store value
//   readdata_i    raw bus read word
//   byteenable_o  active lanes for the access
//   writedata_o   store value replicated onto its lanes
//   load_data_o   extracted and extended load result
//   misaligned_o  access crosses its natural alignment
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] readdata_i,
    output logic [3:0]  byteenable_o,
    output logic [31:0] writedata_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = readdata_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = readdata_i[7:0];
            2'd1: byte_sel = readdata_i[15:8];
            2'd2: byte_sel = readdata_i[23:16];
            2'd3: byte_sel = readdata_i[31:24];
            default: byte_sel = readdata_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? readdata_i[31:16] : readdata_i[15:0];
    end

    always_comb begin
        byteenable_o = BE_WORD;
        writedata_o  = wdata_i;
        load_data_o  = readdata_i;
        misaligned_o = 1'b0;
        case (op_i)
            MEM_LB, MEM_LBU, MEM_SB: begin
                byteenable_o = BE_BYTE << addr_lo_i;
                writedata_o  = {4{wdata_i[7:0]}};
                load_data_o  = (op_i == MEM_LB) ? {{24{byte_sel[7]}}, byte_sel}
                                                : {24'd0, byte_sel};
            end
            MEM_LH, MEM_LHU, MEM_SH: begin
                byteenable_o = BE_HALF << addr_lo_i;
                writedata_o  = {2{wdata_i[15:0]}};
                load_data_o  = (op_i == MEM_LH) ? {{16{half_sel[15]}}, half_sel}
                                                : {16'd0, half_sel};
                misaligned_o = addr_lo_i[0];
            end
            default: begin
                misaligned_o = (addr_lo_i != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - data-memory access stage over an Avalon-MM style bus
// Purpose: accepts one load/store, runs it on the bus, returns a done pulse.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   req_valid_i/req_ready_o   request handshake (ready only when idle)
//   op_i, addr_i, wdata_i     operation, byte address, store value
//   avm_*                     bus master interface with waitrequest
//   done_o                    one-cycle completion pulse
//   load_data_o               extended load result, held between loads
//   misaligned_o              done_o qualifier: trapped, no bus access
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  mem_op_t           op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [ADDR_W-1:0] avm_address_o,
    output logic              avm_read_o,
    output logic              avm_write_o,
    output logic [DATA_W-1:0] avm_writedata_o,
    output logic [3:0]        avm_byteenable_o,
    input  logic              avm_waitrequest_i,
    input  logic [DATA_W-1:0] avm_readdata_i,
    output logic              done_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              misaligned_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

    state_t            state_q, state_d;
    mem_op_t           op_q;
    logic [1:0]        addr_lo_q;
    logic              misal_q;
    logic [ADDR_W-1:0] address_q;
    logic [DATA_W-1:0] writedata_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] load_data_q;

    mem_op_t           align_op;
    logic [1:0]        align_addr;
    logic [3:0]        align_be;
    logic [DATA_W-1:0] align_wdata;
    logic [DATA_W-1:0] align_load;
    logic              align_misal;
    logic              accept;
    logic              load_done;

    // While idle the aligner looks at the incoming request (trap check and
    // lane placement to register); afterwards it extracts the read data
    // using the registered op and offset.
    assign align_op   = (state_q == ST_IDLE) ? op_i : op_q;
    assign align_addr = (state_q == ST_IDLE) ? addr_i[1:0] : addr_lo_q;

    mem_lane_align u_align (
        .op_i        (align_op),
        .addr_lo_i   (align_addr),
        .wdata_i     (wdata_i),
        .readdata_i  (avm_readdata_i),
        .byteenable_o(align_be),
        .writedata_o (align_wdata),
        .load_data_o (align_load),
        .misaligned_o(align_misal)
    );

    assign accept    = req_valid_i && (state_q == ST_IDLE);
    assign load_done = (state_q == ST_BUSY) && !avm_waitrequest_i && !is_store(op_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = align_misal ? ST_RESP : ST_BUSY;
            ST_BUSY: if (!avm_waitrequest_i) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= MEM_LB;
            addr_lo_q   <= 2'd0;
            misal_q     <= 1'b0;
            address_q   <= '0;
            writedata_q <= '0;
            be_q        <= 4'd0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q        <= op_i;
                addr_lo_q   <= addr_i[1:0];
                misal_q     <= align_misal;
                address_q   <= {addr_i[ADDR_W-1:2], 2'b00};
                writedata_q <= align_wdata;
                be_q        <= align_be;
            end
            if (load_done) load_data_q <= align_load;
        end
    end

    // Strobes decode straight from the state register so an async reset
    // drops them immediately.
    assign req_ready_o      = (state_q == ST_IDLE);
    assign avm_read_o       = (state_q == ST_BUSY) && !is_store(op_q);
    assign avm_write_o      = (state_q == ST_BUSY) &&  is_store(op_q);
    assign avm_address_o    = address_q;
    assign avm_writedata_o  = writedata_q;
    assign avm_byteenable_o = be_q;
    assign done_o           = (state_q == ST_RESP);
    assign misaligned_o     = (state_q == ST_RESP) && misal_q;
    assign load_data_o      = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - table-driven bench for mem_access_unit
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    mem_op_t     op_i = MEM_LB;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] avm_address_o;
    logic        avm_read_o;
    logic        avm_write_o;
    logic [31:0] avm_writedata_o;
    logic [3:0]  avm_byteenable_o;
    logic        avm_waitrequest_i = 1'b0;
    logic [31:0] avm_readdata_i = '0;
    logic        done_o;
    logic [31:0] load_data_o;
    logic        misaligned_o;

    int total = 0;
    int bad = 0;
    logic [31:0] last_load = '0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .op_i             (op_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .avm_address_o    (avm_address_o),
        .avm_read_o       (avm_read_o),
        .avm_write_o      (avm_write_o),
        .avm_writedata_o  (avm_writedata_o),
        .avm_byteenable_o (avm_byteenable_o),
        .avm_waitrequest_i(avm_waitrequest_i),
        .avm_readdata_i   (avm_readdata_i),
        .done_o           (done_o),
        .load_data_o      (load_data_o),
        .misaligned_o     (misaligned_o)
    );

    typedef struct {
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_cyc;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic        exp_is_load;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int done_c;
        int sc;
        logic [31:0] exp_ld;
        done_c = -1;
        sc = 0;
        exp_ld = (v.exp_is_load && !v.exp_mis) ? v.exp_load : last_load;
        @(negedge clk);
        chk("ready_before_req", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        op_i = v.op;
        addr_i = v.addr;
        wdata_i = v.wdata;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        op_i = MEM_SW;
        addr_i = 32'hFFFF_FFFF;
        wdata_i = 32'h0BAD_0BAD;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (avm_read_o && avm_write_o) chk("both_strobes", 32'd1, 32'd0);
            if (avm_read_o || avm_write_o) begin
                chk("strobe_is_write", {31'd0, avm_write_o}, {31'd0, !v.exp_is_load});
                chk("address", avm_address_o, v.addr & 32'hFFFF_FFFC);
                chk("byteenable", {28'd0, avm_byteenable_o}, {28'd0, v.exp_be});
                if (!v.exp_is_load) chk("writedata", avm_writedata_o, v.exp_wd);
                chk("ready_busy", {31'd0, req_ready_o}, 32'd0);
                avm_waitrequest_i = (sc < v.wait_cyc);
                avm_readdata_i = (sc < v.wait_cyc) ? ~v.rdata : v.rdata;
                sc++;
            end else begin
                avm_waitrequest_i = 1'b0;
                avm_readdata_i = 32'h5A5A_5A5A;
            end
            if (done_o) begin
                done_c = c;
                chk("misaligned", {31'd0, misaligned_o}, {31'd0, v.exp_mis});
                chk("load_data", load_data_o, exp_ld);
                break;
            end
        end
        chk("done_cycle", done_c, v.exp_mis ? 1 : 2 + v.wait_cyc);
        chk("strobe_cycles", sc, v.exp_mis ? 0 : v.wait_cyc + 1);
        last_load = exp_ld;
    endtask

    initial begin
        vecs[0]  = '{MEM_SW,  32'h100, 32'hDEADBEEF, 32'h0,        0, 1'b0, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{MEM_LB,  32'h203, 32'h0,        32'h80FF1234, 0, 1'b0, 4'b1000, 32'h0,        1'b1, 32'hFFFFFF80};
        vecs[2]  = '{MEM_LBU, 32'h203, 32'h0,        32'h80FF1234, 0, 1'b0, 4'b1000, 32'h0,        1'b1, 32'h00000080};
        vecs[3]  = '{MEM_LH,  32'h302, 32'h0,        32'h9ABC0000, 0, 1'b0, 4'b1100, 32'h0,        1'b1, 32'hFFFF9ABC};
        vecs[4]  = '{MEM_LHU, 32'h302, 32'h0,        32'h9ABC0000, 0, 1'b0, 4'b1100, 32'h0,        1'b1, 32'h00009ABC};
        vecs[5]  = '{MEM_SB,  32'h401, 32'h000000A5, 32'h0,        3, 1'b0, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0};
        vecs[6]  = '{MEM_LW,  32'h502, 32'h0,        32'h12345678, 0, 1'b1, 4'b1111, 32'h0,        1'b1, 32'h0};
        vecs[7]  = '{MEM_SH,  32'h602, 32'h00001234, 32'h0,        1, 1'b0, 4'b1100, 32'h12341234, 1'b0, 32'h0};
        vecs[8]  = '{MEM_LW,  32'h700, 32'h0,        32'h11223344, 2, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h11223344};
        vecs[9]  = '{MEM_LB,  32'h800, 32'h0,        32'hFFFFFF7F, 0, 1'b0, 4'b0001, 32'h0,        1'b1, 32'h0000007F};
        vecs[10] = '{MEM_SH,  32'h901, 32'h0000BEEF, 32'h0,        0, 1'b1, 4'b0110, 32'h0,        1'b0, 32'h0};
        vecs[11] = '{MEM_LHU, 32'hA00, 32'h0,        32'h1234FFFE, 0, 1'b0, 4'b0011, 32'h0,        1'b1, 32'h0000FFFE};
        vecs[12] = '{MEM_SW,  32'hB01, 32'h01020304, 32'h0,        0, 1'b1, 4'b1111, 32'h0,        1'b0, 32'h0};
        vecs[13] = '{MEM_LH,  32'hC03, 32'h0,        32'h0,        0, 1'b1, 4'b1000, 32'h0,        1'b1, 32'h0};
        vecs[14] = '{MEM_LB,  32'hD02, 32'h0,        32'h00C30000, 1, 1'b0, 4'b0100, 32'h0,        1'b1, 32'hFFFFFFC3};

        #12;
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_read", {31'd0, avm_read_o}, 32'd0);
        chk("rst_write", {31'd0, avm_write_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_mis", {31'd0, misaligned_o}, 32'd0);
        chk("rst_addr", avm_address_o, 32'd0);
        chk("rst_wd", avm_writedata_o, 32'd0);
        chk("rst_be", {28'd0, avm_byteenable_o}, 32'd0);
        chk("rst_load", load_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Reset asserted mid-read: strobe must drop without a clock edge.
        @(negedge clk);
        req_valid_i = 1'b1;
        op_i = MEM_LW;
        addr_i = 32'hE00;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        avm_waitrequest_i = 1'b1;
        @(negedge clk);
        chk("midbusy_read", {31'd0, avm_read_o}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_read_drop", {31'd0, avm_read_o}, 32'd0);
        chk("async_ready", {31'd0, req_ready_o}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_done_in_reset", {31'd0, done_o}, 32'd0);
        end
        avm_waitrequest_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("post_rst_done", {31'd0, done_o}, 32'd0);
        chk("post_rst_load", load_data_o, 32'd0);
        last_load = 32'd0;
        run_vec('{MEM_LW, 32'hE04, 32'h0, 32'hCAFEF00D, 0, 1'b0, 4'b1111, 32'h0, 1'b1, 32'hCAFEF00D});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
